cascade_gate_pipe: RTL and testbench

Parametrised, pipelined cascade of two-input logic gates. Operand bit 0 and bit 1 feed the first gate, and each later gate combines the next operand bit with the previous gate's result. Every intermediate tap is returned, with one register stage per gate and valid/ready flow control. The operation is selectable per transaction (NAND/NOR/XOR/XNOR). The block sits between a stimulus source and a result sink in the gate-lab datapath, replacing fixed-width combinational gate chains.

---
 rtl/cascade_gate_pipe.sv | 94 +++++++++
 tb/tb_cascade_gate_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_gate_pipe.sv
// Pipelined cascade of two-input gates with a per-transaction mode.
// Every stage adds one gate tap; one global stall freezes the whole pipe.
module cascade_gate_pipe #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-2:0]   out_taps,
    output logic [1:0]        out_mode,
    output logic              busy,
    output logic [CNT_W-1:0]  res_count
);

    localparam int M = N_IN - 1;

    logic            vld   [M];
    logic [1:0]      md    [M];
    logic [M-1:0]    tp    [M];
    logic [N_IN-1:0] xs    [M];
    logic [M-1:0]    tnext [M];
    logic            advance;

    function automatic logic op(input logic [1:0] m, input logic p, input logic q);
        logic r;
        case (m)
            2'b00:   r = ~(p & q);
            2'b01:   r = ~(p | q);
            2'b10:   r = p ^ q;
            default: r = ~(p ^ q);
        endcase
        return r;
    endfunction

    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign out_valid = vld[M-1];
    assign out_taps  = tp[M-1];
    assign out_mode  = md[M-1];

    always_comb begin
        busy = 1'b0;
        for (int j = 0; j < M; j++) begin
            busy = busy | vld[j];
        end
    end

    // Stage j adds tap j from operand bit j+1 and the previous tap.
    always_comb begin
        tnext[0]    = '0;
        tnext[0][0] = op(in_mode, in_x[0], in_x[1]);
        for (int j = 1; j < M; j++) begin
            tnext[j]    = tp[j-1];
            tnext[j][j] = op(md[j-1], xs[j-1][j+1], tp[j-1][j-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < M; j++) begin
                vld[j] <= 1'b0;
                md[j]  <= 2'b00;
                tp[j]  <= '0;
                xs[j]  <= '0;
            end
        end else if (advance) begin
            vld[0] <= in_valid;
            md[0]  <= in_mode;
            xs[0]  <= in_x;
            tp[0]  <= tnext[0];
            for (int j = 1; j < M; j++) begin
                vld[j] <= vld[j-1];
                md[j]  <= md[j-1];
                xs[j]  <= xs[j-1];
                tp[j]  <= tnext[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (out_valid && out_ready) begin
            res_count <= res_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cascade_gate_pipe.sv
// Randomised and directed bench for cascade_gate_pipe against a
// queue-based model of the gate chain, latency and stall behaviour.
module tb_cascade_gate_pipe;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_x = '0;
    logic [1:0]    in_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-2:0]  out_taps;
    logic [1:0]    out_mode;
    logic          busy;
    logic [CW-1:0] res_count;

    cascade_gate_pipe #(.N_IN(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taps(out_taps), .out_mode(out_mode),
        .busy(busy), .res_count(res_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-2:0] taps;
        logic [1:0]   m;
        int           t;
        int           s;
    } item_t;

    item_t         q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            stalls = 0;
    logic [CW-1:0] mcnt = '0;
    logic          held = 1'b0;
    logic [N-2:0]  held_taps;
    logic [1:0]    held_mode;
    logic          done = 1'b0;

    function automatic logic gate(logic [1:0] m, logic p, logic r);
        case (m)
            2'b00:   return ~(p & r);
            2'b01:   return ~(p | r);
            2'b10:   return p ^ r;
            default: return ~(p ^ r);
        endcase
    endfunction

    function automatic logic [N-2:0] chain(logic [N-1:0] x, logic [1:0] m);
        logic [N-2:0] r;
        logic t;
        t = x[0];
        for (int i = 1; i < N; i++) begin
            t = gate(m, x[i], t);
            r[i-1] = t;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            logic ev;
            ev = (q.size() != 0) &&
                 (cyc - q[0].t - (stalls - q[0].s) >= N - 1);
            chk("res_count", 32'(res_count), 32'(mcnt));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(out_ready || !ev));
            if (held) begin
                chk("hold_taps", 32'(out_taps), 32'(held_taps));
                chk("hold_mode", 32'(out_mode), 32'(held_mode));
            end
            held = 1'b0;
            if (out_valid && ev) begin
                chk("taps", 32'(out_taps), 32'(q[0].taps));
                chk("mode", 32'(out_mode), 32'(q[0].m));
                if (out_ready) begin
                    void'(q.pop_front());
                    mcnt = mcnt + 1'b1;
                end else begin
                    stalls++;
                    held = 1'b1;
                    held_taps = out_taps;
                    held_mode = out_mode;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{chain(in_x, in_mode), in_mode, cyc, stalls});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        mcnt = '0;
        held = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send(logic [N-1:0] x, logic [1:0] m);
        int n;
        logic acc;
        in_valid = 1'b1;
        in_x = x;
        in_mode = m;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(res_count), 32'd0);
        chk("rst_taps", 32'(out_taps), 32'd0);
        chk("rst_mode", 32'(out_mode), 32'd0);

        chk("model_nand", 32'(chain(4'b1111, 2'b00)), 32'b010);
        chk("model_xor", 32'(chain(4'b1101, 2'b10)), 32'b101);
        chk("model_nor", 32'(chain(4'b0000, 2'b01)), 32'b101);

        do_reset();
        send(4'b1111, 2'b00);
        tick();
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_taps", 32'(out_taps), 32'b010);
        tick();
        chk("t1_count", 32'(res_count), 32'd1);

        do_reset();
        send(4'b1101, 2'b10);
        send(4'b0000, 2'b01);
        tick();
        chk("t2_a_taps", 32'({out_valid, out_mode, out_taps}), 32'b1_10_101);
        tick();
        chk("t2_b_taps", 32'({out_valid, out_mode, out_taps}), 32'b1_01_101);
        drain();

        do_reset();
        for (int i = 0; i < 8; i++) send(4'($urandom), 2'($urandom));
        drain();
        chk("t3_count", 32'(res_count), 32'd8);

        do_reset();
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 5; i++) send(4'($urandom), 2'($urandom));
            begin
                repeat (9) tick();
                chk("t4_stalled", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_count", 32'(res_count), 32'd5);

        do_reset();
        for (int i = 0; i < 17; i++) send(4'($urandom), 2'($urandom));
        drain();
        chk("t5_wrap", 32'(res_count), 32'd1);

        do_reset();
        for (int i = 0; i < 3; i++) send(4'($urandom), 2'($urandom));
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_count", 32'(res_count), 32'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();

        do_reset();
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(4'($urandom), 2'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
